// File: rtl/fifo_wr_pkg.sv
// Shared definitions for the async FIFO write-side frame controller:
// input FSM encoding, last-flag position and beat counter width.
package fifo_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BODY    = 2'd1,
        ST_DISCARD = 2'd2
    } wr_state_e;

    localparam int unsigned BEAT_CNT_W = 16;

    // The last flag sits directly above the payload in the FIFO word.
    function automatic int unsigned last_bit_idx(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry registered skid buffer, FIFO ordered; entry 0 is the head.
// ready is registered and high while occupancy after the edge is at most one.
module fifo_skid2 #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             ready
);

    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic             ready_q, ready_d;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop & (occ_q != 2'd0);
    assign push_ok = push & ((occ_q != 2'd2) | pop_ok);

    always_comb begin
        occ_d  = occ_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_d = push_data;
                end else begin
                    ent1_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new beat lands behind whatever stays.
                if (occ_q == 2'd1) begin
                    ent0_d = push_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end
            end
            default: ;
        endcase
        ready_d = (occ_d <= 2'd1);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            occ_q   <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            ready_q <= ready_d;
        end
    end

    assign head_valid = (occ_q != 2'd0);
    assign head_data  = ent0_q;
    assign ready      = ready_q;

endmodule

// File: rtl/fifo_wr_frame_ctrl.sv
// Write-side frame front end: skid-buffers a framed beat stream into the FIFO,
// truncating frames longer than MAX_FRAME_LEN. FIFO_WR_STATS_EN adds counters.
module fifo_wr_frame_ctrl
    import fifo_wr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned MAX_FRAME_LEN = 16,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DATA_WIDTH:0]   wdata,
    output logic                  ovf_err,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int unsigned LAST_IDX = last_bit_idx(DATA_WIDTH);
    localparam int unsigned WORD_W   = DATA_WIDTH + 1;

    wr_state_e             state_q, state_d;
    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [BEAT_CNT_W:0]   cnt_inc;
    logic                  at_max;
    logic                  ovf_err_q, ovf_err_d;
    logic                  accept;
    logic                  push;
    logic                  push_last;
    logic [WORD_W-1:0]     push_word;
    logic                  head_valid;
    logic [WORD_W-1:0]     head_data;
    logic                  skid_ready;

    assign accept  = s_valid & s_ready;
    assign cnt_inc = {1'b0, cnt_q} + {{BEAT_CNT_W{1'b0}}, 1'b1};
    assign at_max  = (cnt_inc == (BEAT_CNT_W + 1)'(MAX_FRAME_LEN));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_last = s_last;
        ovf_err_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_BODY: begin
                if (accept) begin
                    push = 1'b1;
                    if (s_last) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (at_max) begin
                        // Close the frame downstream and swallow its tail.
                        push_last = 1'b1;
                        ovf_err_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_DISCARD;
                    end else begin
                        cnt_d   = cnt_inc[BEAT_CNT_W-1:0];
                        state_d = ST_BODY;
                    end
                end
            end
            ST_DISCARD: begin
                if (accept && s_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    assign push_word = {push_last, s_data};

    fifo_skid2 #(
        .WIDTH (WORD_W)
    ) u_skid (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .push       (push),
        .push_data  (push_word),
        .pop        (winc),
        .head_valid (head_valid),
        .head_data  (head_data),
        .ready      (skid_ready)
    );

    // Both terms are flop outputs; discard mode never pushes, so it ignores occupancy.
    assign s_ready = skid_ready | (state_q == ST_DISCARD);
    assign winc    = head_valid & ~wfull;
    assign wdata   = head_data;
    assign ovf_err = ovf_err_q;

`ifdef FIFO_WR_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (winc && head_data[LAST_IDX]) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
        end
        if (accept && (state_q == ST_DISCARD)) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_frame_ctrl.sv
// Bench for fifo_wr_frame_ctrl: directed frames then random traffic, checked
// against a queue-based model of accepted beats and frame-length rules.
module tb_fifo_wr_frame_ctrl;

    localparam int DW   = 8;
    localparam int MAXL = 4;
    localparam int CW   = 16;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          wfull;
    logic          winc;
    logic [DW:0]   wdata;
    logic          ovf_err;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;

    always #5 wclk = ~wclk;

    fifo_wr_frame_ctrl #(
        .DATA_WIDTH    (DW),
        .MAX_FRAME_LEN (MAXL),
        .CNT_WIDTH     (CW)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .ovf_err   (ovf_err),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: words waiting for the FIFO, open-frame length, discard flag.
    logic [DW:0]   m_q[$];
    int            m_len;
    bit            m_disc;
    bit            m_ready;
    bit            m_ovf;
    bit            m_rst;
    bit            m_known;
    logic [CW-1:0] m_frames;
    logic [CW-1:0] m_drops;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit v, input logic [DW-1:0] d,
                        input bit l, input bit f);
        bit          acc;
        bit          lst;
        logic [DW:0] w;
        @(negedge wclk);
        wrst_n  = rst_n;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        wfull   = f;
        #1;
        if (m_known) begin
            chk("s_ready", 32'(s_ready), 32'(m_ready));
            chk("winc", 32'(winc), 32'((m_q.size() > 0) && !f));
            if (m_q.size() > 0) chk("wdata", 32'(wdata), 32'(m_q[0]));
            else if (m_rst) chk("wdata_rst", 32'(wdata), 32'(0));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
`ifdef FIFO_WR_STATS_EN
            chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`else
            chk("frame_cnt_off", 32'(frame_cnt), 32'(0));
            chk("drop_cnt_off", 32'(drop_cnt), 32'(0));
`endif
        end
        if (!rst_n) begin
            m_q.delete();
            m_len    = 0;
            m_disc   = 0;
            m_ready  = 0;
            m_ovf    = 0;
            m_frames = '0;
            m_drops  = '0;
            m_rst    = 1;
            m_known  = 1;
        end else begin
            m_rst = 0;
            m_ovf = 0;
            acc   = v && m_ready;
            if ((m_q.size() > 0) && !f) begin
                w = m_q.pop_front();
                if (w[DW]) m_frames++;
            end
            if (acc) begin
                if (m_disc) begin
                    m_drops++;
                    if (l) m_disc = 0;
                end else begin
                    m_len++;
                    lst = l;
                    if (!l && m_len == MAXL) begin
                        lst    = 1;
                        m_disc = 1;
                        m_ovf  = 1;
                    end
                    if (lst) m_len = 0;
                    m_q.push_back({lst, d});
                end
            end
            m_ready = m_disc || (m_q.size() <= 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, '0, 0, 0);
    endtask

    initial begin
        m_known  = 0;
        m_rst    = 0;
        m_len    = 0;
        m_disc   = 0;
        m_ready  = 0;
        m_ovf    = 0;
        m_frames = '0;
        m_drops  = '0;
        wrst_n   = 0;
        s_valid  = 0;
        s_data   = '0;
        s_last   = 0;
        wfull    = 0;

        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        idle(2);

        // 4-beat frame
        for (int i = 0; i < 4; i++) step(1, 1, 8'h11 + 8'(i), i == 3, 0);
        idle(3);

        // back-to-back single-beat frames
        step(1, 1, 8'hA0, 1, 0);
        step(1, 1, 8'hA1, 1, 0);
        idle(3);

        // overlong frame, then a normal one
        for (int i = 0; i < 7; i++) step(1, 1, 8'(i), i == 6, 0);
        step(1, 1, 8'h21, 0, 0);
        step(1, 1, 8'h22, 1, 0);
        idle(3);

        // full flag held while streaming, then released
        for (int i = 0; i < 5; i++) step(1, 1, 8'h30 + 8'(i), 0, 1);
        step(1, 0, '0, 0, 0);
        step(1, 1, 8'h3F, 1, 0);
        idle(4);

        // reset in the middle of a frame
        step(1, 1, 8'h41, 0, 0);
        step(1, 1, 8'h42, 0, 0);
        step(0, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        step(1, 1, 8'h55, 1, 0);
        idle(3);

        // random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_frame_ctrl.md
# fifo_wr_frame_ctrl

Write-side front end of the asynchronous FIFO, in the wclk domain directly upstream of the write-pointer/full-flag stage. Accepts a valid/ready beat stream with end-of-frame marker, buffers it in a 2-entry skid buffer, and drives the FIFO write increment and write data, throttled by the registered full flag. Enforces a maximum frame length: overlong frames are truncated with a forced end marker and their tail is discarded.

## Interface
- DATA_WIDTH, 8: payload bits per beat.
- MAX_FRAME_LEN, 16: maximum beats per frame, range 2..65535.
- CNT_WIDTH, 16: width of the statistics counters.

- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, synchronous, active-low. Reset wrst_n, synchronous, active-low; clock wclk.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream ready, registered.
- s_data  in  DATA_WIDTH  upstream payload.
- s_last  in  1  final beat of frame.
- wfull  in  1  registered FIFO full flag from the write-pointer stage.
- winc  out  1  FIFO write increment.
- wdata  out  DATA_WIDTH+1  FIFO write word, {last, payload}.
- ovf_err  out  1  one-cycle pulse when a frame is truncated.
- frame_cnt  out  CNT_WIDTH  frames written (statistics).
- drop_cnt  out  CNT_WIDTH  beats discarded (statistics).

## Operation
- Input FSM states: IDLE (no frame open), BODY (frame open), DISCARD (dropping the tail of an overlong frame).
- Beat accepted when s_valid & s_ready. A beat counter (16 bits) counts accepted beats of the current frame, including the first.
- IDLE/BODY, accepted beat with s_last=1: beat pushed with last=1, counter cleared, next state IDLE.
- IDLE/BODY, accepted beat with s_last=0 and count+1 < MAX_FRAME_LEN: pushed with last=0, next state BODY.
- IDLE/BODY, accepted beat with s_last=0 and count+1 == MAX_FRAME_LEN: pushed with last forced to 1, ovf_err pulses next cycle, next state DISCARD.
- DISCARD: s_ready=1 regardless of buffer state. Beats are consumed and not pushed; drop_cnt increments per beat. The beat with s_last=1 returns the FSM to IDLE.
- Skid buffer: 2 entries, FIFO ordered. Head drives wdata.
- winc = head_valid & ~wfull, combinational. Pop on winc. The write-pointer stage also gates with ~wfull, so no write is ever lost or duplicated.
- frame_cnt increments on each winc whose word has last=1. Both counters wrap modulo 2^CNT_WIDTH.

## Timing
- Reset values: s_ready=0 in the cycle reset is asserted, 1 from the first cycle after release. winc=0, wdata=0, ovf_err=0, counters=0, FSM in IDLE, buffer empty.
- Latency: a beat accepted at edge N is presented on wdata with winc=1 in cycle N+1 when wfull=0.
- Throughput: 1 beat/cycle sustained while wfull=0.
- s_ready (outside DISCARD) is registered and equals 1 iff occupancy after the current edge is ≤1. Both skid entries absorb the in-flight beat, so no beat is lost when wfull rises.
- Simultaneous push and pop on one edge: occupancy unchanged, order preserved.
- wfull held high: head stays stable on wdata and winc=0; at most 2 beats are buffered, then s_ready=0.
- Reset mid-frame: buffer flushed, partial frame abandoned. No last=1 word is synthesized.

## Configuration
- FIFO_WR_STATS_EN defined: frame_cnt and drop_cnt are implemented as described.
- FIFO_WR_STATS_EN undefined: both ports are constant 0 and no counter flops exist. Discarding, truncation and ovf_err are unaffected.

## Structure
- Shared package/include fifo_wr_pkg holds:
  - the FSM state encoding (IDLE=2'd0, BODY=2'd1, DISCARD=2'd2);
  - the last-flag bit index (DATA_WIDTH);
  - the beat counter width constant (16).
- One sub-module, fifo_skid2: 2-entry registered skid buffer with push/pop, head outputs and an occupancy-based ready. Same clock and reset.

## Test plan
- Frame of 4 beats 0x11..0x14 (last on 0x14), wfull=0: winc high for 4 consecutive cycles starting 1 cycle after the first accept; wdata=0x011,0x012,0x013,0x114; frame_cnt=1.
- Back-to-back 1-beat frames 0xA0,0xA1 with last=1: wdata=0x1A0,0x1A1 on consecutive cycles; frame_cnt=2; FSM stays IDLE.
- MAX_FRAME_LEN=4, 7-beat frame 0..6: wdata=0x000,0x001,0x002,0x103; ovf_err pulses once; beats 4..6 dropped; drop_cnt=3; next frame accepted normally.
- wfull forced high while streaming: winc=0, s_ready falls after 2 buffered beats, wdata stable. On wfull release, the buffered beats emit in order with no loss or duplication.
- Reset asserted mid-frame after 2 beats: next cycle winc=0 and counters=0. A fresh frame 0x55 (last) emits wdata=0x155.
- FIFO_WR_STATS_EN undefined, rerun the overflow scenario: frame_cnt=drop_cnt=0; data and ovf_err identical to the statistics build.
